// File: rtl/fifo_pattern_tester.sv
// Burst/gap FIFO write-traffic generator with an independent read-side checker.
// Define FIFO_TESTER_LFSR_EN to compile in the 32-bit LFSR pattern selected by lfsr_mode.

module fifo_pattern_tester #(
  parameter int DSIZE     = 8,
  parameter int BURST_LEN = 2,
  parameter int GAP_LEN   = 1,
  parameter int SEED      = 0,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             clear,
  input  logic             lfsr_mode,
  input  logic             rd_stall,
  output logic             wr_en,
  output logic [DSIZE-1:0] wr_data,
  input  logic             wr_full,
  output logic             rd_en,
  input  logic [DSIZE-1:0] rd_data,
  input  logic             rd_empty,
  output logic [CNT_W-1:0] tx_count,
  output logic [CNT_W-1:0] rx_count,
  output logic [CNT_W-1:0] err_count,
  output logic             err_flag,
  output logic [DSIZE-1:0] first_exp,
  output logic [DSIZE-1:0] first_act,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int GW = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
  localparam logic [BW-1:0]    BURST_LAST = BW'(BURST_LEN - 1);
  localparam logic [GW-1:0]    GAP_LAST   = GW'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);
  localparam logic             GAP_NONE   = (GAP_LEN == 0);
  localparam logic [BW-1:0]    BURST_ONE  = BW'(1'b1);
  localparam logic [GW-1:0]    GAP_ONE    = GW'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1'b1);
  localparam logic [DSIZE-1:0] INC_ONE    = DSIZE'(1'b1);
  localparam logic [DSIZE-1:0] SEED_W     = DSIZE'(SEED);

  state_t           state_r;
  state_t           state_nx_s;
  logic [BW-1:0]    burst_cnt_r;
  logic [BW-1:0]    burst_cnt_nx_s;
  logic [GW-1:0]    gap_cnt_r;
  logic [GW-1:0]    gap_cnt_nx_s;
  logic             init_s;
  logic             wr_en_s;
  logic             rd_en_s;
  logic             mismatch_s;
  logic [DSIZE-1:0] wr_inc_r;
  logic [DSIZE-1:0] exp_inc_r;
  logic [DSIZE-1:0] wr_word_s;
  logic [DSIZE-1:0] exp_word_s;
  logic [CNT_W-1:0] tx_count_r;
  logic [CNT_W-1:0] rx_count_r;
  logic [CNT_W-1:0] err_count_r;
  logic             err_flag_r;
  logic [DSIZE-1:0] first_exp_r;
  logic [DSIZE-1:0] first_act_r;

`ifdef FIFO_TESTER_LFSR_EN
  localparam logic [31:0] LFSR_SEED = 32'hFFFF_FFFF;

  logic        lfsr_mode_r;
  logic [31:0] wr_lfsr_r;
  logic [31:0] exp_lfsr_r;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction
`else
  logic unused_lfsr_mode_s;
  assign unused_lfsr_mode_s = lfsr_mode;
`endif

  assign init_s     = rst | clear;
  assign rd_en_s    = !rd_empty && !rd_stall;
  assign mismatch_s = rd_en_s && (rd_data != exp_word_s);

  // Pattern select: both generators always present the same pattern family.
  always_comb begin
    wr_word_s  = wr_inc_r;
    exp_word_s = exp_inc_r;
`ifdef FIFO_TESTER_LFSR_EN
    if (lfsr_mode_r) begin
      wr_word_s  = wr_lfsr_r[DSIZE-1:0];
      exp_word_s = exp_lfsr_r[DSIZE-1:0];
    end else begin
      wr_word_s  = wr_inc_r;
      exp_word_s = exp_inc_r;
    end
`endif
  end

  // Writer state register.
  always_ff @(posedge clk) begin
    if (init_s) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Writer next-state; a dropped enable abandons the burst from any state.
  always_comb begin
    state_nx_s     = state_r;
    burst_cnt_nx_s = burst_cnt_r;
    gap_cnt_nx_s   = gap_cnt_r;
    wr_en_s        = (state_r == BURST) && !wr_full;
    case (state_r)
      IDLE: begin
        burst_cnt_nx_s = '0;
        gap_cnt_nx_s   = '0;
        if (enable) begin
          state_nx_s = BURST;
        end else begin
          state_nx_s = IDLE;
        end
      end
      BURST: begin
        if (!enable) begin
          state_nx_s     = IDLE;
          burst_cnt_nx_s = '0;
        end else if (wr_en_s) begin
          if (burst_cnt_r == BURST_LAST) begin
            burst_cnt_nx_s = '0;
            gap_cnt_nx_s   = '0;
            if (GAP_NONE) begin
              state_nx_s = BURST;
            end else begin
              state_nx_s = GAP;
            end
          end else begin
            burst_cnt_nx_s = burst_cnt_r + BURST_ONE;
          end
        end else begin
          state_nx_s = BURST;
        end
      end
      GAP: begin
        if (!enable) begin
          state_nx_s   = IDLE;
          gap_cnt_nx_s = '0;
        end else if (gap_cnt_r == GAP_LAST) begin
          state_nx_s   = BURST;
          gap_cnt_nx_s = '0;
        end else begin
          gap_cnt_nx_s = gap_cnt_r + GAP_ONE;
        end
      end
      default: begin
        state_nx_s     = IDLE;
        burst_cnt_nx_s = '0;
        gap_cnt_nx_s   = '0;
      end
    endcase
  end

  // Writer counters and write-side generator; the pattern mode is latched on init only.
  always_ff @(posedge clk) begin
    if (init_s) begin
      burst_cnt_r <= '0;
      gap_cnt_r   <= '0;
      tx_count_r  <= '0;
      wr_inc_r    <= SEED_W;
`ifdef FIFO_TESTER_LFSR_EN
      wr_lfsr_r   <= LFSR_SEED;
      lfsr_mode_r <= lfsr_mode;
`endif
    end else begin
      burst_cnt_r <= burst_cnt_nx_s;
      gap_cnt_r   <= gap_cnt_nx_s;
      if (wr_en_s) begin
        tx_count_r <= tx_count_r + CNT_ONE;
        wr_inc_r   <= wr_inc_r + INC_ONE;
`ifdef FIFO_TESTER_LFSR_EN
        wr_lfsr_r  <= lfsr_next(wr_lfsr_r);
`endif
      end
    end
  end

  // Reader check: the expected generator advances on every pop, even a mismatching one.
  always_ff @(posedge clk) begin
    if (init_s) begin
      rx_count_r  <= '0;
      err_count_r <= '0;
      err_flag_r  <= 1'b0;
      first_exp_r <= '0;
      first_act_r <= '0;
      exp_inc_r   <= SEED_W;
`ifdef FIFO_TESTER_LFSR_EN
      exp_lfsr_r  <= LFSR_SEED;
`endif
    end else if (rd_en_s) begin
      rx_count_r <= rx_count_r + CNT_ONE;
      exp_inc_r  <= exp_inc_r + INC_ONE;
`ifdef FIFO_TESTER_LFSR_EN
      exp_lfsr_r <= lfsr_next(exp_lfsr_r);
`endif
      if (mismatch_s) begin
        if (err_count_r != '1) begin
          err_count_r <= err_count_r + CNT_ONE;
        end
        if (!err_flag_r) begin
          err_flag_r  <= 1'b1;
          first_exp_r <= exp_word_s;
          first_act_r <= rd_data;
        end
      end
    end
  end

  assign wr_en     = wr_en_s;
  assign wr_data   = wr_word_s;
  assign rd_en     = rd_en_s;
  assign tx_count  = tx_count_r;
  assign rx_count  = rx_count_r;
  assign err_count = err_count_r;
  assign err_flag  = err_flag_r;
  assign first_exp = first_exp_r;
  assign first_act = first_act_r;
  assign done      = (state_r == IDLE) && !enable && (tx_count_r == rx_count_r);

endmodule
